// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// IDLE->BUSY->RESP per access, with fetch anti-starvation, a busy watchdog and sticky error flags.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_rd_en,
  input  logic        d_wr_en,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        stall_if,
  output logic        stall_d,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        err_clr,
  output logic        err_timeout,
  output logic        err_proto
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [CNT_W-1:0] L_STARVE   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] L_TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic             r_owner_if;
  logic             r_is_wr;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] r_busy_cnt;

  logic             w_d_pend;
  logic             w_grant_d;
  logic             w_timeout;
  logic             w_abort;
  logic [CNT_W-1:0] w_starve_inc;

  assign w_d_pend     = d_rd_en | d_wr_en;
  // Data wins unless fetch has already waited through STARVE_LIMIT data grants.
  assign w_grant_d    = w_d_pend && ((STARVE_LIMIT == 0) || (r_starve_cnt < L_STARVE) || !if_req);
  assign w_timeout    = (TIMEOUT != 0) && (r_busy_cnt == L_TMO_LAST) && !mem_ready;
  assign w_abort      = (r_state == S_BUSY) && w_timeout;
  assign w_starve_inc = (r_starve_cnt == '1) ? r_starve_cnt : r_starve_cnt + CNT_W'(1);

  assign stall_if = if_req & ~if_ack;
  assign stall_d  = w_d_pend & ~d_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_owner_if   <= 1'b0;
      r_is_wr      <= 1'b0;
      r_starve_cnt <= '0;
      r_busy_cnt   <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      if_rdata     <= '0;
      if_ack       <= 1'b0;
      d_rdata      <= '0;
      d_ack        <= 1'b0;
      err_timeout  <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      // Set beats clear when both happen in the same cycle.
      err_proto   <= (d_rd_en & d_wr_en) | (err_proto & ~err_clr);
      err_timeout <= w_abort | (err_timeout & ~err_clr);

      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state      <= S_BUSY;
            r_owner_if   <= 1'b0;
            r_is_wr      <= d_wr_en;
            mem_addr     <= d_addr;
            mem_rd       <= ~d_wr_en;
            mem_wr       <= d_wr_en;
            r_busy_cnt   <= '0;
            r_starve_cnt <= if_req ? w_starve_inc : '0;
            if (d_wr_en) mem_wdata <= d_wdata;
          end else if (if_req) begin
            r_state      <= S_BUSY;
            r_owner_if   <= 1'b1;
            r_is_wr      <= 1'b0;
            mem_addr     <= if_addr;
            mem_rd       <= 1'b1;
            mem_wr       <= 1'b0;
            r_busy_cnt   <= '0;
            r_starve_cnt <= '0;
          end
        end
        S_BUSY: begin
          r_busy_cnt <= r_busy_cnt + CNT_W'(1);
          if (mem_ready || w_timeout) begin
            r_state <= S_RESP;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            if (r_owner_if) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= (mem_ready && !r_is_wr) ? mem_rdata : '0;
            end
          end
        end
        S_RESP: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inline checks plus an ack scoreboard
// filled when a request is driven and drained by a negedge monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_rd_en, d_wr_en, mem_ready, err_clr;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, stall_if, stall_d, mem_rd, mem_wr, err_timeout, err_proto;

  typedef struct packed {logic is_if; logic [31:0] data;} exp_t;
  exp_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_rd_en(d_rd_en), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .stall_if(stall_if), .stall_d(stall_d),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_clr(err_clr),
    .err_timeout(err_timeout), .err_proto(err_proto)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string tag, input bit is_if, input int max, output int n);
    n = 0;
    while (!(is_if ? if_ack : d_ack) && n < max) begin
      tick();
      n++;
    end
    chk(tag, is_if ? if_ack : d_ack, 1'b1);
  endtask

  // Scoreboard drain: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (if_ack || d_ack)) begin
      exp_t e;
      chk("ack_exclusive", {if_ack, d_ack} == 2'b11, 1'b0);
      chk("ack_expected", q.size() > 0, 1'b1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ack_owner", if_ack, e.is_if);
        chk("ack_data", e.is_if ? if_rdata : d_rdata, e.data);
      end
    end
  end

  initial begin
    int n, c_d, c_if;
    bit owner_if;
    logic [31:0] exp_addr;

    rst = 1'b0; if_req = 0; d_rd_en = 0; d_wr_en = 0; mem_ready = 0; err_clr = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

    // Reset
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_buses", {mem_addr, mem_wdata, if_rdata, d_rdata}, '0);
    chk("rst_flags", {mem_rd, mem_wr, if_ack, d_ack, stall_if, stall_d, err_timeout, err_proto}, '0);

    // Single load, memory ready on the second BUSY cycle
    d_rd_en = 1; d_addr = 32'h100;
    #1 chk("load_stall_pre", stall_d, 1'b1);
    q.push_back('{is_if: 1'b0, data: 32'hDEADBEEF});
    tick();
    chk("load_b1", {mem_rd, mem_wr, mem_addr, stall_d}, {1'b1, 1'b0, 32'h100, 1'b1});
    tick();
    chk("load_b2", {mem_rd, stall_d, d_ack}, 3'b110);
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk("load_resp", {d_ack, d_rdata, mem_rd, stall_d}, {1'b1, 32'hDEADBEEF, 1'b0, 1'b0});
    d_rd_en = 0; mem_ready = 0; mem_rdata = 32'h0;
    tick();
    chk("load_hold", {d_ack, d_rdata}, {1'b0, 32'hDEADBEEF});

    // Contention: store first, then fetch, acks 3 cycles apart
    if_req = 1; if_addr = 32'h40;
    d_wr_en = 1; d_addr = 32'h200; d_wdata = 32'h12345678;
    mem_ready = 1; mem_rdata = 32'hCAFE0040;
    q.push_back('{is_if: 1'b0, data: 32'h0});
    q.push_back('{is_if: 1'b1, data: 32'hCAFE0040});
    tick();
    chk("st_busy", {mem_wr, mem_rd, mem_addr, mem_wdata}, {1'b1, 1'b0, 32'h200, 32'h12345678});
    tick();
    chk("st_resp", {d_ack, if_ack, d_rdata, stall_if}, {1'b1, 1'b0, 32'h0, 1'b1});
    c_d = cyc;
    d_wr_en = 0;
    tick();
    tick();
    chk("fe_busy", {mem_rd, mem_wr, mem_addr}, {1'b1, 1'b0, 32'h40});
    tick();
    chk("fe_resp", {if_ack, if_rdata, stall_if}, {1'b1, 32'hCAFE0040, 1'b0});
    c_if = cyc;
    chk("ack_spacing", c_if - c_d, 3);
    if_req = 0;
    tick();

    // Starvation: 4 data grants, 1 fetch, then data again
    if_req = 1; if_addr = 32'h80; d_rd_en = 1; d_addr = 32'h300;
    mem_ready = 1; mem_rdata = 32'h11;
    for (int i = 0; i < 6; i++) begin
      owner_if = (i == 4);
      q.push_back('{is_if: owner_if, data: 32'h11});
    end
    for (int i = 0; i < 6; i++) begin
      owner_if = (i == 4);
      exp_addr = owner_if ? 32'h80 : 32'h300;
      n = 0;
      do begin tick(); n++; end while (!(mem_rd || mem_wr) && n < 6);
      chk($sformatf("starve_grant%0d", i), {mem_rd, mem_addr}, {1'b1, exp_addr});
      wait_ack($sformatf("starve_ack%0d", i), owner_if, 6, n);
      if (i == 5) begin if_req = 0; d_rd_en = 0; end
    end
    tick();

    // Watchdog abort on a fetch with memory never ready
    mem_ready = 0; mem_rdata = 32'hBAD0BAD0;
    if_req = 1; if_addr = 32'h44;
    q.push_back('{is_if: 1'b1, data: 32'h0});
    tick();
    chk("tmo_busy", {mem_rd, mem_addr}, {1'b1, 32'h44});
    wait_ack("tmo_ack", 1'b1, 100, n);
    chk("tmo_cycle", n + 1, 65);
    chk("tmo_resp", {if_rdata, err_timeout, mem_rd}, {32'h0, 1'b1, 1'b0});
    if_req = 0;
    tick();
    chk("tmo_sticky", err_timeout, 1'b1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("tmo_clr", err_timeout, 1'b0);

    // Protocol violation: treated as a store, err_proto sticky, set beats clear
    d_rd_en = 1; d_wr_en = 1; d_addr = 32'h400; d_wdata = 32'hA5A5A5A5;
    mem_ready = 1; mem_rdata = 32'h77777777;
    q.push_back('{is_if: 1'b0, data: 32'h0});
    tick();
    chk("pv_busy", {mem_wr, mem_rd, err_proto, mem_wdata}, {1'b1, 1'b0, 1'b1, 32'hA5A5A5A5});
    err_clr = 1;
    tick();
    chk("pv_resp", {d_ack, d_rdata, err_proto}, {1'b1, 32'h0, 1'b1});
    err_clr = 0; d_rd_en = 0; d_wr_en = 0;
    tick();
    chk("pv_sticky", err_proto, 1'b1);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("pv_clr", err_proto, 1'b0);

    // Reset in the middle of BUSY discards the access
    mem_ready = 0; if_req = 1; if_addr = 32'h48;
    tick();
    chk("mrst_busy", mem_rd, 1'b1);
    #2 rst = 1'b0;
    #1 chk("mrst_drop", {mem_rd, mem_wr}, 2'b00);
    if_req = 0;
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_buses", {mem_addr, mem_wdata, if_rdata, d_rdata}, '0);
    chk("mrst_flags", {mem_rd, mem_wr, if_ack, d_ack, stall_if, stall_d, err_timeout, err_proto}, '0);
    chk("sb_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
